// File: rtl/bin_bcd_pkg.sv
// Shared types and sizing for the binary-to-BCD converter.
// Holds the FSM state enum and the datapath widths used by the
// converter top, its digit-correction cells and the bus interface.
package bin_bcd_pkg;

    localparam int unsigned BIN_W   = 8;   // binary input width
    localparam int unsigned BCD_MAX = 99;  // largest value representable in two digits
    localparam int unsigned CNT_W   = 3;   // shift counter width (counts 0..7)
    localparam int unsigned DIG_W   = 4;   // one BCD digit
    localparam int unsigned HUND_W  = 2;   // internal hundreds digit (max 2 for 8-bit input)

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

endpackage

// File: rtl/bin_bcd_conv_if.sv
// Request/result bus of the binary-to-BCD converter.
// Signals:
//   start_i  conversion request (master -> slave)
//   bin_i    unsigned binary value (master -> slave)
//   busy_o   conversion in progress (slave -> master)
//   valid_o  one-cycle pulse, bcd_o updated (slave -> master)
//   bcd_o    packed BCD {tens, units} (slave -> master)
//   ovf_o    last converted value exceeded 99 (slave -> master)
// Modports: master (requester), slave (converter).
interface bin_bcd_conv_if;
    import bin_bcd_pkg::*;

    logic                   start_i;
    logic [BIN_W-1:0]       bin_i;
    logic                   busy_o;
    logic                   valid_o;
    logic [2*DIG_W-1:0]     bcd_o;
    logic                   ovf_o;

    modport master (
        output start_i,
        output bin_i,
        input  busy_o,
        input  valid_o,
        input  bcd_o,
        input  ovf_o
    );

    modport slave (
        input  start_i,
        input  bin_i,
        output busy_o,
        output valid_o,
        output bcd_o,
        output ovf_o
    );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is >= 5 so
// the following left shift carries correctly into the next digit.
// Ports:
//   digit    current 4-bit BCD digit
//   fixed_c  corrected digit (combinational)
module bcd_add3
    import bin_bcd_pkg::*;
(
    input  logic [DIG_W-1:0] digit,
    output logic [DIG_W-1:0] fixed_c
);

    assign fixed_c = (digit >= DIG_W'(5)) ? digit + DIG_W'(3) : digit;

endmodule

// File: rtl/bin_bcd_conv.sv
// Sequential 8-bit binary to 2-digit packed BCD converter using the
// shift-add-3 (double-dabble) algorithm, one bit per clock; the result
// appears exactly 8 clocks after the accepting edge.
// Ports:
//   clk_i    system clock, rising edge
//   rst_n_i  synchronous active-low reset
//   bus      bin_bcd_conv_if.slave (start_i, bin_i, busy_o, valid_o, bcd_o, ovf_o)
// Build option BIN_BCD_SAT_EN: when defined, inputs above 99 saturate to 99
// at load; when undefined, a 2-bit hundreds digit is kept internally and the
// output is the value mod 100. ovf_o is the same in both builds.
module bin_bcd_conv
    import bin_bcd_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    bin_bcd_conv_if.slave   bus
);

    localparam logic [0:0] ST_IDLE = 1'(IDLE);
    localparam logic [0:0] ST_CONV = 1'(CONV);

    logic [0:0]         state,   state_nxt;
    logic [CNT_W-1:0]   cnt,     cnt_nxt;
    logic [BIN_W-1:0]   bin_sr,  bin_nxt;
    logic [DIG_W-1:0]   tens,    tens_nxt;
    logic [DIG_W-1:0]   units,   units_nxt;
`ifndef BIN_BCD_SAT_EN
    logic [HUND_W-1:0]  hund,    hund_nxt;
`endif
    logic               busy,    busy_nxt;
    logic               valid,   valid_nxt;
    logic [2*DIG_W-1:0] bcd,     bcd_nxt;
    logic               ovf,     ovf_nxt;

    logic [DIG_W-1:0]   tens_fix;
    logic [DIG_W-1:0]   units_fix;
    logic [BIN_W-1:0]   load_val;
    logic               in_ovf;

    // One correction cell per BCD digit
    bcd_add3 u_add3_units (.digit(units), .fixed_c(units_fix));
    bcd_add3 u_add3_tens  (.digit(tens),  .fixed_c(tens_fix));

    assign in_ovf = (bus.bin_i > BIN_W'(BCD_MAX));

`ifdef BIN_BCD_SAT_EN
    assign load_val = in_ovf ? BIN_W'(BCD_MAX) : bus.bin_i;
`else
    assign load_val = bus.bin_i;
`endif

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bin_nxt   = bin_sr;
        tens_nxt  = tens;
        units_nxt = units;
`ifndef BIN_BCD_SAT_EN
        hund_nxt  = hund;
`endif
        busy_nxt  = busy;
        valid_nxt = 1'b0;
        bcd_nxt   = bcd;
        ovf_nxt   = ovf;

        if (state == ST_IDLE) begin
            if (bus.start_i) begin
                state_nxt = ST_CONV;
                cnt_nxt   = '0;
                bin_nxt   = load_val;
                tens_nxt  = '0;
                units_nxt = '0;
`ifndef BIN_BCD_SAT_EN
                hund_nxt  = '0;
`endif
                busy_nxt  = 1'b1;
                ovf_nxt   = in_ovf;
            end
        end else begin
            // Correct digits, then shift the whole register left by one
`ifdef BIN_BCD_SAT_EN
            {tens_nxt, units_nxt, bin_nxt} = {tens_fix, units_fix, bin_sr} << 1;
`else
            {hund_nxt, tens_nxt, units_nxt, bin_nxt} =
                {hund, tens_fix, units_fix, bin_sr} << 1;
`endif
            cnt_nxt = cnt + CNT_W'(1);
            // Eighth shift: publish the result; start_i is not looked at here
            if (cnt == CNT_W'(BIN_W - 1)) begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
                valid_nxt = 1'b1;
                bcd_nxt   = {tens_nxt, units_nxt};
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            bin_sr <= '0;
            tens   <= '0;
            units  <= '0;
`ifndef BIN_BCD_SAT_EN
            hund   <= '0;
`endif
            busy   <= 1'b0;
            valid  <= 1'b0;
            bcd    <= '0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            bin_sr <= bin_nxt;
            tens   <= tens_nxt;
            units  <= units_nxt;
`ifndef BIN_BCD_SAT_EN
            hund   <= hund_nxt;
`endif
            busy   <= busy_nxt;
            valid  <= valid_nxt;
            bcd    <= bcd_nxt;
            ovf    <= ovf_nxt;
        end
    end

    assign bus.busy_o  = busy;
    assign bus.valid_o = valid;
    assign bus.bcd_o   = bcd;
    assign bus.ovf_o   = ovf;

endmodule

// File: tb/tb_bin_bcd_conv.sv
// Self-checking bench for bin_bcd_conv: directed boundary/scenario tests plus
// random values checked against an arithmetic (div/mod) reference model.
module tb_bin_bcd_conv;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bin_bcd_conv_if bus();

    bin_bcd_conv dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal value shown on the two output digits
    function automatic logic [7:0] exp_bcd(input int v);
        int m;
`ifdef BIN_BCD_SAT_EN
        m = (v > 99) ? 99 : v;
`else
        m = v % 100;
`endif
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    // Issue one request and observe up to 12 following edges
    task automatic run_conv(input logic [7:0] v, output logic [7:0] bcd,
                            output logic ovf, output int lat, output int pulses);
        lat    = -1;
        pulses = 0;
        bcd    = 'x;
        ovf    = 'x;
        bus.start_i = 1'b1;
        bus.bin_i   = v;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            bus.bin_i = 8'($urandom);
            @(posedge clk); #1;
            if (bus.valid_o === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    bcd = bus.bcd_o;
                    ovf = bus.ovf_o;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.start_i = 1'b1;
        bus.bin_i   = 8'd57;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.busy_o, bus.valid_o, bus.ovf_o, bus.bcd_o} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b valid=%b ovf=%b bcd=%h want all 0",
                     bus.busy_o, bus.valid_o, bus.ovf_o, bus.bcd_o);
        end
        bus.start_i = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_priority busy=%b want 0", bus.busy_o);
        end
    endtask

    task automatic test_fixed();
        int vals[5] = '{57, 0, 99, 200, 255};
        logic [7:0] bcd;
        logic       ovf;
        int         lat, pulses;
        foreach (vals[i]) begin
            run_conv(8'(vals[i]), bcd, ovf, lat, pulses);
            total++;
            if (bcd !== exp_bcd(vals[i])) begin
                bad++;
                $display("FAIL fixed_bcd v=%0d got %h want %h", vals[i], bcd, exp_bcd(vals[i]));
            end
            total++;
            if (ovf !== (vals[i] > 99)) begin
                bad++;
                $display("FAIL fixed_ovf v=%0d got %b want %b", vals[i], ovf, vals[i] > 99);
            end
            total++;
            if (lat != 8 || pulses != 1) begin
                bad++;
                $display("FAIL fixed_timing v=%0d latency=%0d pulses=%0d want 8 and 1",
                         vals[i], lat, pulses);
            end
            total++;
            if (bus.bcd_o !== exp_bcd(vals[i]) || bus.busy_o !== 1'b0) begin
                bad++;
                $display("FAIL fixed_hold v=%0d bcd=%h busy=%b want %h and 0",
                         vals[i], bus.bcd_o, bus.busy_o, exp_bcd(vals[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] bcd;
        logic       ovf;
        int         lat, pulses, v;
        for (int n = 0; n < 16; n++) begin
            v = int'($urandom_range(0, 255));
            run_conv(8'(v), bcd, ovf, lat, pulses);
            total++;
            if (bcd !== exp_bcd(v) || ovf !== (v > 99) || lat != 8 || pulses != 1) begin
                bad++;
                $display("FAIL random v=%0d bcd=%h ovf=%b lat=%0d pulses=%0d want %h %b 8 1",
                         v, bcd, ovf, lat, pulses, exp_bcd(v), v > 99);
            end
            total++;
            if (bcd[7:4] > 4'd9 || bcd[3:0] > 4'd9) begin
                bad++;
                $display("FAIL random_legal v=%0d bcd=%h want digits <= 9", v, bcd);
            end
        end
    endtask

    task automatic test_busy_collision();
        int         lat = -1;
        int         pulses = 0;
        logic [7:0] bcd = 'x;
        logic       busy_e9 = 'x;
        bus.start_i = 1'b1;
        bus.bin_i   = 8'd42;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            bus.start_i = (k == 3 || k == 8);
            bus.bin_i   = 8'd13;
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            if (bus.valid_o === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    bcd = bus.bcd_o;
                end
            end
            if (k == 9) busy_e9 = bus.busy_o;
        end
        total++;
        if (pulses != 1 || lat != 8) begin
            bad++;
            $display("FAIL collision_pulses got pulses=%0d first=%0d want 1 at 8", pulses, lat);
        end
        total++;
        if (bcd !== 8'h42) begin
            bad++;
            $display("FAIL collision_bcd got %h want 42", bcd);
        end
        total++;
        if (busy_e9 !== 1'b0) begin
            bad++;
            $display("FAIL collision_busy_e9 got %b want 0", busy_e9);
        end
    endtask

    task automatic test_reset_mid();
        int         pulses = 0;
        logic [7:0] bcd;
        logic       ovf;
        int         lat, p2;
        bus.start_i = 1'b1;
        bus.bin_i   = 8'd77;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({bus.busy_o, bus.valid_o, bus.ovf_o, bus.bcd_o} !== 11'd0) begin
            bad++;
            $display("FAIL midreset_outputs got busy=%b valid=%b ovf=%b bcd=%h want all 0",
                     bus.busy_o, bus.valid_o, bus.ovf_o, bus.bcd_o);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.valid_o === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL midreset_no_valid got %0d pulses want 0", pulses);
        end
        run_conv(8'd5, bcd, ovf, lat, p2);
        total++;
        if (bcd !== 8'h05 || lat != 8 || p2 != 1) begin
            bad++;
            $display("FAIL midreset_restart got bcd=%h lat=%0d pulses=%0d want 05 8 1",
                     bcd, lat, p2);
        end
    endtask

    task automatic test_back_to_back();
        int         at[2]  = '{-1, -1};
        logic [7:0] got[2] = '{8'hxx, 8'hxx};
        int         pulses = 0;
        bus.start_i = 1'b1;
        bus.bin_i   = 8'd12;
        @(posedge clk); #1;
        for (int k = 1; k <= 20; k++) begin
            bus.start_i = (k == 9);
            bus.bin_i   = (k == 9) ? 8'd34 : 8'($urandom);
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            if (bus.valid_o === 1'b1) begin
                if (pulses < 2) begin
                    at[pulses]  = k;
                    got[pulses] = bus.bcd_o;
                end
                pulses++;
            end
        end
        total++;
        if (pulses != 2 || at[0] != 8 || at[1] != 17) begin
            bad++;
            $display("FAIL b2b_timing pulses=%0d at=%0d,%0d want 2 at 8,17", pulses, at[0], at[1]);
        end
        total++;
        if (got[0] !== 8'h12 || got[1] !== 8'h34) begin
            bad++;
            $display("FAIL b2b_bcd got %h,%h want 12,34", got[0], got[1]);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.bin_i   = '0;
        test_reset();
        test_fixed();
        test_random();
        test_busy_collision();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
